// File: rtl/hist_pkg.sv
// Shared types and default sizes for the histogram readout block.
package hist_pkg;

    localparam int HIST_MA_SIZE = 4;
    localparam int HIST_CNT_W   = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } hist_state_e;

endpackage

// File: rtl/hist_peak_tracker.sv
// Running maximum over streamed bins; strict greater-than keeps the lowest index on ties.
// One cycle update latency, no backpressure (observes transfers only).
module hist_peak_tracker
    import hist_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int CNT_W = HIST_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid,
    input  logic [IDX_W-1:0] index,
    input  logic [CNT_W-1:0] count,
    output logic [IDX_W-1:0] max_index,
    output logic [CNT_W-1:0] max_count
);

    logic [IDX_W-1:0] max_index_q, max_index_d;
    logic [CNT_W-1:0] max_count_q, max_count_d;

    always_comb begin
        max_index_d = max_index_q;
        max_count_d = max_count_q;
        if (clear) begin
            max_index_d = '0;
            max_count_d = '0;
        end else if (valid && (count > max_count_q)) begin
            max_index_d = index;
            max_count_d = count;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_index_q <= '0;
            max_count_q <= '0;
        end else begin
            max_index_q <= max_index_d;
            max_count_q <= max_count_d;
        end
    end

    assign max_index = max_index_q;
    assign max_count = max_count_q;

endmodule

// File: rtl/hist_readout.sv
// Snapshots the bin matrix on start and streams it bin-by-bin (valid/ready), reporting the peak bin.
// First beat one cycle after start, 1 bin/cycle; beats hold stable while out_ready is low.
module hist_readout
    import hist_pkg::*;
#(
    parameter int  MA_SIZE = HIST_MA_SIZE,
    parameter int  CNT_W   = HIST_CNT_W,
    localparam int NBINS   = MA_SIZE * MA_SIZE,
    localparam int IDX_W   = $clog2(NBINS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NBINS*CNT_W-1:0] matrix,
    input  logic                   start,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [CNT_W-1:0]       out_data,
    output logic [IDX_W-1:0]       out_index,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W-1:0]       peak_index,
    output logic [CNT_W-1:0]       peak_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBINS - 1);

    hist_state_e              state_q, state_d;
    logic [NBINS*CNT_W-1:0]   snap_q, snap_d;
    logic                     out_valid_q, out_valid_d;
    logic [CNT_W-1:0]         out_data_q, out_data_d;
    logic [IDX_W-1:0]         out_index_q, out_index_d;
    logic                     out_last_q, out_last_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [IDX_W-1:0]         peak_index_q, peak_index_d;
    logic [CNT_W-1:0]         peak_count_q, peak_count_d;

    logic                     frame_start;
    logic                     xfer;
    logic [IDX_W-1:0]         next_index;
    logic [IDX_W-1:0]         trk_index;
    logic [CNT_W-1:0]         trk_count;

    assign frame_start = (state_q == IDLE) && start;
    assign xfer        = (state_q == STREAM) && out_valid_q && out_ready;
    assign next_index  = out_index_q + IDX_W'(1);

    hist_peak_tracker #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_peak (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (frame_start),
        .valid     (xfer),
        .index     (out_index_q),
        .count     (out_data_q),
        .max_index (trk_index),
        .max_count (trk_count)
    );

    // The snapshot is a shift register: bin 0 goes straight to out_data on start,
    // the remaining bins shift down one slot per transfer so the next bin is always at the bottom.
    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_index_d  = out_index_q;
        out_last_d   = out_last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        peak_index_d = peak_index_q;
        peak_count_d = peak_count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = STREAM;
                    snap_d      = matrix >> CNT_W;
                    out_data_d  = matrix[CNT_W-1:0];
                    out_index_d = '0;
                    out_valid_d = 1'b1;
                    out_last_d  = (NBINS == 1);
                    busy_d      = 1'b1;
                end
            end
            STREAM: begin
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        state_d     = DONE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        out_index_d = next_index;
                        out_data_d  = snap_q[CNT_W-1:0];
                        snap_d      = snap_q >> CNT_W;
                        out_last_d  = (next_index == LAST_IDX);
                    end
                end
            end
            DONE: begin
                // Tracker has absorbed the last transfer by now, so this is the final peak.
                state_d      = IDLE;
                busy_d       = 1'b0;
                peak_index_d = trk_index;
                peak_count_d = trk_count;
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            snap_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_index_q  <= '0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            peak_index_q <= '0;
            peak_count_q <= '0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_index_q  <= out_index_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            peak_index_q <= peak_index_d;
            peak_count_q <= peak_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_index  = out_index_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign peak_index = peak_index_q;
    assign peak_count = peak_count_q;

endmodule

// File: tb/tb_hist_readout.sv
// Directed bench for hist_readout: ramp, backpressure, ties, snapshot, saturation, mid-frame reset.
module tb_hist_readout;

    localparam int MA = 4;
    localparam int CW = 9;
    localparam int N  = MA * MA;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*CW-1:0] matrix;
    logic            start;
    logic            out_ready;
    logic            out_valid;
    logic [CW-1:0]   out_data;
    logic [IW-1:0]   out_index;
    logic            out_last;
    logic            busy;
    logic            done;
    logic [IW-1:0]   peak_index;
    logic [CW-1:0]   peak_count;

    int n_cmp = 0;
    int n_err = 0;

    int bd [64];
    int bi [64];
    int bl [64];
    int nb;
    int done_cyc;
    int hold_err;
    int timeout;

    always #5 clk = ~clk;

    hist_readout #(.MA_SIZE(MA), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .matrix     (matrix),
        .start      (start),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .peak_index (peak_index),
        .peak_count (peak_count)
    );

    task automatic set_bin(input int i, input int v);
        matrix[i*CW +: CW] = CW'(v);
    endtask

    // Start is driven for one full cycle; returns at the negedge of the first cycle after it was sampled.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Records beats until done; mode 0: ready high, 1: ready 1,0,0,1 pattern, 2: ready high plus a start re-pulse.
    task automatic run_frame(input int mode);
        int k;
        logic pv, pr, pl;
        logic [CW-1:0] pd;
        logic [IW-1:0] pi;
        nb = 0; done_cyc = -1; hold_err = 0; timeout = 1;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pi = '0;
        for (int cyc = 2; cyc < 300; cyc++) begin
            k = cyc - 2;
            if (mode == 1) out_ready = ((k % 4) == 0) || ((k % 4) == 3);
            else           out_ready = 1'b1;
            if (mode == 2) start = (k == 5);
            if (done) begin
                done_cyc = cyc;
                timeout  = 0;
                break;
            end
            if (pv && !pr) begin
                if (!out_valid) hold_err++;
                else if (out_data !== pd || out_index !== pi || out_last !== pl) hold_err++;
            end
            if (out_valid && out_ready && nb < 64) begin
                bd[nb] = int'(out_data);
                bi[nb] = int'(out_index);
                bl[nb] = int'(out_last);
                nb++;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pi = out_index; pl = out_last;
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; matrix = '0;
        #13;
        n_cmp++;
        if ({out_valid, out_last, busy, done} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags got=%b want=0000", {out_valid, out_last, busy, done});
        end
        n_cmp++;
        if (out_data !== '0 || out_index !== '0 || peak_index !== '0 || peak_count !== '0) begin
            n_err++; $display("FAIL reset_values got data=%0d idx=%0d pk=%0d/%0d want all 0",
                              out_data, out_index, peak_index, peak_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        for (int i = 0; i < N; i++) set_bin(i, i);
        pulse_start();
        run_frame(0);
        n_cmp++;
        if (timeout != 0 || nb != N) begin
            n_err++; $display("FAIL ramp_beats got=%0d timeout=%0d want=%0d", nb, timeout, N);
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (bd[i] != i || bi[i] != i || bl[i] != ((i == N - 1) ? 1 : 0)) begin
                n_err++; $display("FAIL ramp_beat%0d got d=%0d i=%0d l=%0d want d=%0d i=%0d l=%0d",
                                  i, bd[i], bi[i], bl[i], i, i, (i == N - 1) ? 1 : 0);
            end
        end
        n_cmp++;
        if (done_cyc != 18) begin
            n_err++; $display("FAIL ramp_done_cycle got=%0d want=18", done_cyc);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL ramp_done_state got valid=%b busy=%b want 0/1", out_valid, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (peak_index !== 4'd15 || peak_count !== 9'd15) begin
            n_err++; $display("FAIL ramp_peak got=(%0d,%0d) want=(15,15)", peak_index, peak_count);
        end
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL ramp_done_pulse got done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < N; i++) set_bin(i, i);
        pulse_start();
        run_frame(1);
        n_cmp++;
        if (timeout != 0 || nb != N) begin
            n_err++; $display("FAIL bp_beats got=%0d timeout=%0d want=%0d", nb, timeout, N);
        end
        n_cmp++;
        if (hold_err != 0) begin
            n_err++; $display("FAIL bp_hold got=%0d unstable stalls want=0", hold_err);
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (bd[i] != i || bi[i] != i || bl[i] != ((i == N - 1) ? 1 : 0)) begin
                n_err++; $display("FAIL bp_beat%0d got d=%0d i=%0d l=%0d want d=%0d i=%0d", i, bd[i], bi[i], bl[i], i, i);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (peak_index !== 4'd15 || peak_count !== 9'd15) begin
            n_err++; $display("FAIL bp_peak got=(%0d,%0d) want=(15,15)", peak_index, peak_count);
        end
    endtask

    task automatic test_ties();
        for (int i = 0; i < N; i++) set_bin(i, 5);
        set_bin(3, 200);
        set_bin(9, 200);
        pulse_start();
        run_frame(0);
        @(negedge clk);
        n_cmp++;
        if (peak_index !== 4'd3 || peak_count !== 9'd200) begin
            n_err++; $display("FAIL ties_peak got=(%0d,%0d) want=(3,200)", peak_index, peak_count);
        end
        n_cmp++;
        if (nb != N || bd[9] != 200 || bd[4] != 5) begin
            n_err++; $display("FAIL ties_data got n=%0d b9=%0d b4=%0d want 16/200/5", nb, bd[9], bd[4]);
        end
    endtask

    task automatic test_snapshot();
        int extra;
        for (int i = 0; i < N; i++) set_bin(i, i + 20);
        set_bin(0, 7);
        pulse_start();
        set_bin(0, 8);
        run_frame(2);
        n_cmp++;
        if (nb != N || bd[0] != 7) begin
            n_err++; $display("FAIL snap_bin0 got n=%0d d0=%0d want n=16 d0=7", nb, bd[0]);
        end
        n_cmp++;
        if (bd[15] != 35 || bi[15] != 15) begin
            n_err++; $display("FAIL snap_last got d=%0d i=%0d want 35/15", bd[15], bi[15]);
        end
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid || (c > 0 && busy)) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++; $display("FAIL snap_single_frame got=%0d active cycles after done want=0", extra);
        end
        n_cmp++;
        if (peak_index !== 4'd15 || peak_count !== 9'd35) begin
            n_err++; $display("FAIL snap_peak got=(%0d,%0d) want=(15,35)", peak_index, peak_count);
        end
    endtask

    task automatic test_saturated();
        int bad;
        for (int i = 0; i < N; i++) set_bin(i, 511);
        pulse_start();
        run_frame(0);
        bad = 0;
        for (int i = 0; i < N; i++) if (bd[i] != 511) bad++;
        n_cmp++;
        if (nb != N || bad != 0) begin
            n_err++; $display("FAIL sat_data got n=%0d bad=%0d want 16/0", nb, bad);
        end
        @(negedge clk);
        n_cmp++;
        if (peak_index !== 4'd0 || peak_count !== 9'd511) begin
            n_err++; $display("FAIL sat_peak got=(%0d,%0d) want=(0,511)", peak_index, peak_count);
        end
    endtask

    task automatic test_mid_reset();
        int got;
        for (int i = 0; i < N; i++) set_bin(i, i);
        pulse_start();
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (out_valid) got++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL mrst_flags got v=%b b=%b d=%b want 0/0/0", out_valid, busy, done);
        end
        n_cmp++;
        if (peak_index !== '0 || peak_count !== '0 || out_index !== '0) begin
            n_err++; $display("FAIL mrst_values got pk=(%0d,%0d) idx=%0d want 0", peak_index, peak_count, out_index);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL mrst_no_resume got v=%b b=%b want 0/0", out_valid, busy);
        end
        pulse_start();
        run_frame(0);
        n_cmp++;
        if (nb != N || bi[0] != 0 || bd[0] != 0 || bd[15] != 15) begin
            n_err++; $display("FAIL mrst_restart got n=%0d i0=%0d d0=%0d d15=%0d want 16/0/0/15", nb, bi[0], bd[0], bd[15]);
        end
    endtask

    task automatic test_all_zero();
        matrix = '0;
        pulse_start();
        run_frame(0);
        @(negedge clk);
        n_cmp++;
        if (timeout != 0 || peak_index !== 4'd0 || peak_count !== 9'd0) begin
            n_err++; $display("FAIL zero_peak got=(%0d,%0d) timeout=%0d want=(0,0)", peak_index, peak_count, timeout);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_ties();
        test_snapshot();
        test_saturated();
        test_mid_reset();
        test_all_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
